seven_seg_scanner: RTL and testbench

//  Multiplexed N-digit hex seven-segment driver and successor to the single-digit decoder.

---
 rtl/seven_seg_if.sv | 35 +++
 rtl/seven_seg_scanner.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// seven_seg_if: bundles the data/control inputs and display outputs of the
// seven-segment scanner.
//   value      4*DIGITS  hex nibbles, digit 0 rightmost
//   dp         DIGITS    decimal point request per digit
//   blink_en   DIGITS    blink request per digit
//   blank_lz   1         blank leading zeros
//   load       1         capture value/dp/blink_en/blank_lz this edge
//   seg        7         {g,f,e,d,c,b,a}
//   dot        1         decimal point
//   an         DIGITS    digit enables, one active at a time
//   frame_done 1         pulse when the scan index wraps to 0
// master drives the requests (score logic / bench), slave is the scanner.
interface seven_seg_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blink_en;
    logic                blank_lz;
    logic                load;
    logic [6:0]          seg;
    logic                dot;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output value, dp, blink_en, blank_lz, load,
        input  seg, dot, an, frame_done
    );

    modport slave (
        input  value, dp, blink_en, blank_lz, load,
        output seg, dot, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed N-digit hex seven-segment driver.
// A shadow copy of value/dp/blink_en/blank_lz is taken on load; the display
// runs only from the shadow. A prescaler sets the digit slot length, a scan
// index selects the digit, and a frame counter drives the blink phase.
// seg/dot/an are registered every cycle from (shadow, index, blink phase).
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, outputs go to the off level
//   bus  seven_seg_if slave modport (see interface for signal list)
module seven_seg_scanner #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    seven_seg_if.slave  bus
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]     PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0]     FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DOT_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = DIG_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            4'hF:    hex_to_seg = 7'h71;
            default: hex_to_seg = 7'h00;
        endcase
    endfunction

    logic [4*DIGITS-1:0] val_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   blink_r;
    logic                lz_r;
    logic [PW-1:0]       pre_r;
    logic [IW-1:0]       idx_r;
    logic [FW-1:0]       frm_r;
    logic                phase_r;
    logic [6:0]          seg_r;
    logic                dot_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_done_r;

    logic                tick_s;
    logic                wrap_s;
    logic [DIGITS-1:0]   sel_s;
    logic [DIGITS-1:0]   lz_mask_s;
    logic                lz_run_s;
    logic [3:0]          nib_s;
    logic                blank_s;
    logic [6:0]          seg_lit_s;
    logic                dot_lit_s;

    assign tick_s = (pre_r == PRE_LAST);
    assign wrap_s = tick_s && (idx_r == IDX_LAST);

    // Shadow registers: capture the display request on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_r   <= '0;
            dp_r    <= '0;
            blink_r <= '0;
            lz_r    <= 1'b0;
        end else if (bus.load) begin
            val_r   <= bus.value;
            dp_r    <= bus.dp;
            blink_r <= bus.blink_en;
            lz_r    <= bus.blank_lz;
        end else begin
            val_r   <= val_r;
            dp_r    <= dp_r;
            blink_r <= blink_r;
            lz_r    <= lz_r;
        end
    end

    // Prescaler, scan index and blink frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r   <= '0;
            idx_r   <= '0;
            frm_r   <= '0;
            phase_r <= 1'b0;
        end else begin
            pre_r <= tick_s ? '0 : pre_r + 1'b1;
            if (tick_s) begin
                idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
            end else begin
                idx_r <= idx_r;
            end
            if (wrap_s) begin
                if (frm_r == FRM_LAST) begin
                    frm_r   <= '0;
                    phase_r <= ~phase_r;
                end else begin
                    frm_r   <= frm_r + 1'b1;
                    phase_r <= phase_r;
                end
            end else begin
                frm_r   <= frm_r;
                phase_r <= phase_r;
            end
        end
    end

    // Digit select, leading-zero mask and blanking for the current slot.
    // The leading-zero run walks down from the top digit and stops at the
    // first non-zero nibble or set dp; digit 0 is always excluded so 0 shows "0".
    always_comb begin
        sel_s     = '0;
        lz_mask_s = '0;
        lz_run_s  = 1'b1;
        nib_s     = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            sel_s[i]     = (idx_r == IW'(i));
            lz_run_s     = lz_run_s & (val_r[4*i +: 4] == 4'h0) & ~dp_r[i];
            lz_mask_s[i] = lz_run_s & (i != 0);
            nib_s        = nib_s | (val_r[4*i +: 4] & {4{sel_s[i]}});
        end
        blank_s   = ((|(blink_r & sel_s)) & phase_r) | (lz_r & (|(lz_mask_s & sel_s)));
        seg_lit_s = blank_s ? 7'h00 : hex_to_seg(nib_s);
        dot_lit_s = (|(dp_r & sel_s)) & ~blank_s;
    end

    // Registered output stage with polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            dot_r        <= DOT_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= SEG_ACTIVE_LOW ? ~seg_lit_s : seg_lit_s;
            dot_r        <= SEG_ACTIVE_LOW ? ~dot_lit_s : dot_lit_s;
            an_r         <= DIG_ACTIVE_LOW ? ~sel_s : sel_s;
            frame_done_r <= wrap_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dot        = dot_r;
    assign bus.an         = an_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seven_seg_if #(.DIGITS(4)) bus_a ();
    seven_seg_if #(.DIGITS(1)) bus_b ();

    seven_seg_scanner #(
        .DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    seven_seg_scanner #(
        .DIGITS(1), .CLK_DIV(1), .BLINK_FRAMES(64),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Active-high segment codes for 0..F.
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] lo(input logic [3:0] n);
        return ~SEG_TBL[n];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
        bus_a.value    = v;
        bus_a.dp       = d;
        bus_a.blink_en = b;
        bus_a.blank_lz = lz;
        bus_a.load     = 1'b1;
        tick();
        bus_a.load     = 1'b0;
        tick();
    endtask

    task automatic load_b(input logic [3:0] v, input logic d, input logic lz);
        bus_b.value    = v;
        bus_b.dp       = d;
        bus_b.blink_en = 1'b0;
        bus_b.blank_lz = lz;
        bus_b.load     = 1'b1;
        tick();
        bus_b.load     = 1'b0;
        tick();
    endtask

    // Wait (bounded) until digit d of dut_a is the enabled one.
    task automatic wait_an(input int d);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << d);
        n = 0;
        while (bus_a.an !== want && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("timeout_an", 32'(n), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic        bl [8];
        int          n;
        int          blanks;
        int          trans;

        bus_a.value = 16'h0000; bus_a.dp = 4'h0; bus_a.blink_en = 4'h0;
        bus_a.blank_lz = 1'b0; bus_a.load = 1'b0;
        bus_b.value = 4'h0; bus_b.dp = 1'b0; bus_b.blink_en = 1'b0;
        bus_b.blank_lz = 1'b0; bus_b.load = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_seg_a", 32'(bus_a.seg), 32'h7F);
        check("rst_dot_a", 32'(bus_a.dot), 32'h1);
        check("rst_an_a", 32'(bus_a.an), 32'hF);
        check("rst_fd_a", 32'(bus_a.frame_done), 32'h0);
        check("rst_seg_b", 32'(bus_b.seg), 32'h00);
        check("rst_dot_b", 32'(bus_b.dot), 32'h0);
        check("rst_an_b", 32'(bus_b.an), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("first_an_a", 32'(bus_a.an), 32'hE);
        check("first_seg_a", 32'(bus_a.seg), 32'h40);
        check("first_an_b", 32'(bus_b.an), 32'h1);
        check("first_fd_b", 32'(bus_b.frame_done), 32'h1);

        // T2: plain scan of 12AF
        v = 16'h12AF;
        load_a(v, 4'h0, 4'h0, 1'b0);
        for (int d = 0; d < 4; d++) begin
            wait_an(d);
            check("t2_seg", 32'(bus_a.seg), 32'(lo(v[4*d +: 4])));
            check("t2_dot", 32'(bus_a.dot), 32'h1);
        end
        wait_an(0);
        wait_an(1);
        n = 0;
        while (bus_a.an === 4'b1101 && n < 16) begin
            tick();
            n++;
        end
        check("t2_slot_len", 32'(n), 32'd4);
        check("t2_next_an", 32'(bus_a.an), 32'hB);
        n = 0;
        for (int c = 0; c < 32; c++) begin
            if (bus_a.frame_done === 1'b1) n++;
            tick();
        end
        check("t2_frame_pulses", 32'(n), 32'd2);

        // T1: reset mid-scan, outputs off immediately, shadow cleared
        rst = 1'b1;
        #1;
        check("mid_rst_seg", 32'(bus_a.seg), 32'h7F);
        check("mid_rst_dot", 32'(bus_a.dot), 32'h1);
        check("mid_rst_an", 32'(bus_a.an), 32'hF);
        check("mid_rst_fd", 32'(bus_a.frame_done), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_an", 32'(bus_a.an), 32'hE);
        check("post_rst_seg", 32'(bus_a.seg), 32'h40);

        // T3: leading-zero blanking
        load_a(16'h0050, 4'h0, 4'h0, 1'b1);
        wait_an(3);
        check("t3_d3_seg", 32'(bus_a.seg), 32'h7F);
        check("t3_d3_dot", 32'(bus_a.dot), 32'h1);
        wait_an(2);
        check("t3_d2_seg", 32'(bus_a.seg), 32'h7F);
        wait_an(1);
        check("t3_d1_seg", 32'(bus_a.seg), 32'(lo(4'h5)));
        wait_an(0);
        check("t3_d0_seg", 32'(bus_a.seg), 32'(lo(4'h0)));
        load_a(16'h0050, 4'b1000, 4'h0, 1'b1);
        wait_an(3);
        check("t3_dp_d3_seg", 32'(bus_a.seg), 32'(lo(4'h0)));
        check("t3_dp_d3_dot", 32'(bus_a.dot), 32'h0);
        wait_an(2);
        check("t3_dp_d2_seg", 32'(bus_a.seg), 32'(lo(4'h0)));
        check("t3_dp_d2_dot", 32'(bus_a.dot), 32'h1);
        load_a(16'h0000, 4'h0, 4'h0, 1'b1);
        wait_an(1);
        check("t3_zero_d1", 32'(bus_a.seg), 32'h7F);
        wait_an(0);
        check("t3_zero_d0", 32'(bus_a.seg), 32'(lo(4'h0)));

        // T4: blink digit 0, 2-frame half period
        load_a(16'h12AF, 4'h0, 4'b0001, 1'b0);
        blanks = 0;
        for (int f = 0; f < 8; f++) begin
            wait_an(0);
            bl[f] = (bus_a.seg === 7'h7F);
            if (bl[f]) blanks++;
            else check("t4_d0_lit", 32'(bus_a.seg), 32'(lo(4'hF)));
            wait_an(1);
            check("t4_d1_steady", 32'(bus_a.seg), 32'(lo(4'hA)));
        end
        trans = 0;
        for (int f = 1; f < 8; f++) begin
            if (bl[f] != bl[f-1]) trans++;
        end
        check("t4_blank_frames", 32'(blanks), 32'd4);
        check("t4_pair_windows", 32'((trans == 3) || (trans == 4)), 32'd1);

        // T5: load on the same edge the index advances
        load_a(16'h12AF, 4'h0, 4'h0, 1'b0);
        wait_an(0);
        wait_an(1);
        tick();
        tick();
        bus_a.value = 16'h5B7E;
        bus_a.load  = 1'b1;
        tick();
        bus_a.load  = 1'b0;
        check("t5_old_an", 32'(bus_a.an), 32'hD);
        check("t5_old_seg", 32'(bus_a.seg), 32'(lo(4'hA)));
        tick();
        check("t5_new_an", 32'(bus_a.an), 32'hB);
        check("t5_new_seg", 32'(bus_a.seg), 32'(lo(4'hB)));
        bus_a.value = 16'h8888;
        wait_an(3);
        check("t5_noload_d3", 32'(bus_a.seg), 32'(lo(4'h5)));
        wait_an(0);
        check("t5_noload_d0", 32'(bus_a.seg), 32'(lo(4'hE)));
        wait_an(2);
        check("t5_noload_d2", 32'(bus_a.seg), 32'(lo(4'hB)));

        // T6: active-high polarity, single digit, CLK_DIV=1
        load_b(4'h8, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("t6_an", 32'(bus_b.an), 32'h1);
            check("t6_seg8", 32'(bus_b.seg), 32'h7F);
            check("t6_fd", 32'(bus_b.frame_done), 32'h1);
            tick();
        end
        load_b(4'h0, 1'b1, 1'b1);
        check("t6_zero_seg", 32'(bus_b.seg), 32'h3F);
        check("t6_zero_dot", 32'(bus_b.dot), 32'h1);
        check("t6_zero_an", 32'(bus_b.an), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
